tlb_assoc: RTL and testbench



---
 rtl/tlb_pkg.sv | 34 +++
 rtl/tlb_lru_ages.sv | 42 ++++
 rtl/tlb_assoc.sv | 146 ++++++++++++++
 tb/tb_tlb_assoc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared constants, response type and LRU age-update helpers for the associative TLB.
package tlb_pkg;

  localparam int unsigned DEF_ENTRIES   = 4;
  localparam int unsigned DEF_VA_W      = 32;
  localparam int unsigned DEF_PA_W      = 20;
  localparam int unsigned DEF_PAGE_BITS = 12;

  // Sized for the widest physical address any instance may use; instances slice it down.
  localparam int unsigned PADDR_MAX_W = 64;

  typedef struct packed {
    logic                   hit;
    logic                   miss;
    logic [PADDR_MAX_W-1:0] paddr;
  } tlb_resp_t;

  // Make the target MRU; everything more recent than it ages by one.
  function automatic int unsigned age_touch(input int unsigned age, input int unsigned ref_age,
                                            input logic target);
    if (target) return 0;
    if (age < ref_age) return age + 1;
    return age;
  endfunction

  // Make the target LRU; everything older than it gets one step younger.
  function automatic int unsigned age_demote(input int unsigned age, input int unsigned ref_age,
                                             input logic target, input int unsigned entries);
    if (target) return entries - 1;
    if (age > ref_age) return age - 1;
    return age;
  endfunction

endpackage

// File: rtl/tlb_lru_ages.sv
// True-LRU age array: ages form a permutation of 0..ENTRIES-1, 0 = MRU, ENTRIES-1 = victim.
module tlb_lru_ages #(
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned AGE_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_en_i,
  input  logic [AGE_W-1:0] touch_idx_i,
  input  logic             demote_en_i,
  input  logic [AGE_W-1:0] demote_idx_i,
  output logic [AGE_W-1:0] victim_idx_o
);
  import tlb_pkg::*;

  logic [ENTRIES-1:0][AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0]              ref_age;

  always_comb begin
    age_d        = age_q;
    victim_idx_o = '0;
    ref_age      = demote_en_i ? age_q[demote_idx_i] : age_q[touch_idx_i];
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (age_q[i] == AGE_W'(ENTRIES - 1)) victim_idx_o = AGE_W'(i);
      if (demote_en_i) begin
        age_d[i] = AGE_W'(age_demote(32'(age_q[i]), 32'(ref_age), AGE_W'(i) == demote_idx_i,
                                     ENTRIES));
      end else if (touch_en_i) begin
        age_d[i] = AGE_W'(age_touch(32'(age_q[i]), 32'(ref_age), AGE_W'(i) == touch_idx_i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= AGE_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB with true-LRU replacement, supervisor bypass and a registered response.
module tlb_assoc #(
  parameter  int unsigned ENTRIES   = tlb_pkg::DEF_ENTRIES,
  parameter  int unsigned VA_W      = tlb_pkg::DEF_VA_W,
  parameter  int unsigned PA_W      = tlb_pkg::DEF_PA_W,
  parameter  int unsigned PAGE_BITS = tlb_pkg::DEF_PAGE_BITS,
  localparam int unsigned VPN_W     = VA_W - PAGE_BITS,
  localparam int unsigned PPN_W     = PA_W - PAGE_BITS,
  localparam int unsigned AGE_W     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [VA_W-1:0]  vaddr,
  input  logic             supervisor_mode,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             inv_en,
  input  logic [VPN_W-1:0] inv_vpn,
  output logic             resp_valid,
  output logic [PA_W-1:0]  paddr,
  output logic             hit,
  output logic             miss
);
  import tlb_pkg::*;

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][VPN_W-1:0] vpn_q, vpn_d;
  logic [ENTRIES-1:0][PPN_W-1:0] ppn_q, ppn_d;
  logic                          resp_valid_q, resp_valid_d;
  tlb_resp_t                     resp_q, resp_d;

  logic [VPN_W-1:0]   lk_vpn;
  logic [ENTRIES-1:0] lk_match, wr_match, inv_match;
  logic [AGE_W-1:0]   lk_idx, wr_hit_idx, free_idx, inv_idx, wr_slot, victim_idx, touch_idx;
  logic               touch_en, demote_en;
  logic               unused_paddr_hi;

  assign lk_vpn = vaddr[VA_W-1:PAGE_BITS];

  // Descending scan so the lowest matching index wins every priority encode.
  always_comb begin
    lk_idx     = '0;
    wr_hit_idx = '0;
    free_idx   = '0;
    inv_idx    = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      lk_match[i]  = valid_q[i] && (vpn_q[i] == lk_vpn);
      wr_match[i]  = valid_q[i] && (vpn_q[i] == wr_vpn);
      inv_match[i] = valid_q[i] && (vpn_q[i] == inv_vpn);
      if (lk_match[i])  lk_idx     = AGE_W'(i);
      if (wr_match[i])  wr_hit_idx = AGE_W'(i);
      if (inv_match[i]) inv_idx    = AGE_W'(i);
      if (!valid_q[i])  free_idx   = AGE_W'(i);
    end
    if (|wr_match)        wr_slot = wr_hit_idx;
    else if (!(&valid_q)) wr_slot = free_idx;
    else                  wr_slot = victim_idx;
  end

  always_comb begin
    valid_d   = valid_q;
    vpn_d     = vpn_q;
    ppn_d     = ppn_q;
    touch_en  = 1'b0;
    touch_idx = lk_idx;
    demote_en = 1'b0;
    if (flush) begin
      valid_d = '0;
    end else if (inv_en) begin
      if (|inv_match) begin
        valid_d[inv_idx] = 1'b0;
        demote_en        = 1'b1;
      end
    end else if (wr_en) begin
      valid_d[wr_slot] = 1'b1;
      vpn_d[wr_slot]   = wr_vpn;
      ppn_d[wr_slot]   = wr_ppn;
      touch_en         = 1'b1;
      touch_idx        = wr_slot;
    end else if (lookup_valid && !supervisor_mode && (|lk_match)) begin
      touch_en = 1'b1;
    end
  end

  // Response always reflects the contents held before this cycle's updates.
  always_comb begin
    resp_valid_d = lookup_valid;
    resp_d       = resp_q;
    if (lookup_valid) begin
      resp_d.paddr = '0;
      if (supervisor_mode) begin
        resp_d.hit               = 1'b1;
        resp_d.miss              = 1'b0;
        resp_d.paddr[PA_W-1:0]   = vaddr[PA_W-1:0];
      end else if (|lk_match) begin
        resp_d.hit               = 1'b1;
        resp_d.miss              = 1'b0;
        resp_d.paddr[PA_W-1:0]   = {ppn_q[lk_idx], vaddr[PAGE_BITS-1:0]};
      end else begin
        resp_d.hit  = 1'b0;
        resp_d.miss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      vpn_q        <= '0;
      ppn_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      valid_q      <= valid_d;
      vpn_q        <= vpn_d;
      ppn_q        <= ppn_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  tlb_lru_ages #(
    .ENTRIES(ENTRIES)
  ) u_ages (
    .clk         (clk),
    .reset       (reset),
    .touch_en_i  (touch_en),
    .touch_idx_i (touch_idx),
    .demote_en_i (demote_en),
    .demote_idx_i(inv_idx),
    .victim_idx_o(victim_idx)
  );

  assign resp_valid      = resp_valid_q;
  assign hit             = resp_q.hit;
  assign miss            = resp_q.miss;
  assign paddr           = resp_q.paddr[PA_W-1:0];
  assign unused_paddr_hi = ^resp_q.paddr[PADDR_MAX_W-1:PA_W];

  // In-place updates make duplicate VPNs impossible; catch any path that breaks that.
  assert property (@(posedge clk) disable iff (reset) $onehot0(lk_match));

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: directed scenarios plus random traffic against a recency-list model.
module tb_tlb_assoc;
  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0, flush = 1'b0, lookup_valid = 1'b0, supervisor_mode = 1'b0;
  logic        wr_en = 1'b0, inv_en = 1'b0;
  logic [31:0] vaddr = '0;
  logic [19:0] wr_vpn = '0, inv_vpn = '0;
  logic [7:0]  wr_ppn = '0;
  logic        resp_valid, hit, miss;
  logic [19:0] paddr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic [19:0] paddr;
  } exp_t;

  exp_t exp_q[$];

  // Model: mapping table plus a recency list (front = most recent, back = next victim).
  bit          m_valid[ENTRIES];
  logic [19:0] m_vpn[ENTRIES];
  logic [7:0]  m_ppn[ENTRIES];
  int          order[$];

  tlb_assoc dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .lookup_valid   (lookup_valid),
    .vaddr          (vaddr),
    .supervisor_mode(supervisor_mode),
    .wr_en          (wr_en),
    .wr_vpn         (wr_vpn),
    .wr_ppn         (wr_ppn),
    .inv_en         (inv_en),
    .inv_vpn        (inv_vpn),
    .resp_valid     (resp_valid),
    .paddr          (paddr),
    .hit            (hit),
    .miss           (miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int m_find(input logic [19:0] vpn);
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  function automatic void m_move(input int e, input bit to_front);
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] == e) begin
        order.delete(k);
        break;
      end
    end
    if (to_front) order.push_front(e);
    else order.push_back(e);
  endfunction

  function automatic void m_reset();
    order.delete();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      order.push_back(i);
    end
  endfunction

  function automatic exp_t m_lookup(input logic [31:0] va, input logic sup);
    exp_t e;
    int   h;
    e = '0;
    if (sup) begin
      e.hit   = 1'b1;
      e.paddr = va[19:0];
    end else begin
      h = m_find(va[31:12]);
      if (h >= 0) begin
        e.hit   = 1'b1;
        e.paddr = {m_ppn[h], va[11:0]};
      end else begin
        e.miss = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic m_update();
    int h, s;
    h = m_find(vaddr[31:12]);
    s = -1;
    if (reset) begin
      m_reset();
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (inv_en) begin
      s = m_find(inv_vpn);
      if (s >= 0) begin
        m_valid[s] = 1'b0;
        m_move(s, 1'b0);
      end
    end else if (wr_en) begin
      s = m_find(wr_vpn);
      for (int i = 0; i < ENTRIES; i++) if (s < 0 && !m_valid[i]) s = i;
      if (s < 0) s = order[$];
      m_valid[s] = 1'b1;
      m_vpn[s]   = wr_vpn;
      m_ppn[s]   = wr_ppn;
      m_move(s, 1'b1);
    end else if (lookup_valid && !supervisor_mode && h >= 0) begin
      m_move(h, 1'b1);
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic tick(input bit fixed_en, input exp_t fixed);
    if (lookup_valid && !reset) exp_q.push_back(fixed_en ? fixed : m_lookup(vaddr, supervisor_mode));
    m_update();
    @(posedge clk);
    #1;
    {reset, flush, lookup_valid, supervisor_mode, wr_en, inv_en} = '0;
  endtask

  task automatic look(input logic [31:0] va, input logic sup, input logic h, input logic [19:0] pa);
    exp_t e;
    e.hit           = h;
    e.miss          = ~h;
    e.paddr         = pa;
    lookup_valid    = 1'b1;
    vaddr           = va;
    supervisor_mode = sup;
    tick(1'b1, e);
  endtask

  task automatic wr(input logic [19:0] v, input logic [7:0] p);
    wr_en  = 1'b1;
    wr_vpn = v;
    wr_ppn = p;
    tick(1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, '0);
  endtask

  task automatic fill();
    for (int k = 1; k <= 4; k++) wr(20'(k), 8'(k * 8'h11));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid=1 with no lookup outstanding");
      end else begin
        e = exp_q.pop_front();
        check("resp_hit", 64'(hit), 64'(e.hit));
        check("resp_miss", 64'(miss), 64'(e.miss));
        check("resp_paddr", 64'(paddr), 64'(e.paddr));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("reset_resp_valid", 64'(resp_valid), 64'(0));
    check("reset_hit", 64'(hit), 64'(0));
    check("reset_miss", 64'(miss), 64'(0));
    check("reset_paddr", 64'(paddr), 64'(0));
    @(posedge clk);
    #1;

    // Basic translate and miss.
    fill();
    look(32'h0000_2ABC, 1'b0, 1'b1, 20'h22ABC);
    look(32'h0000_9000, 1'b0, 1'b0, 20'h00000);

    // LRU eviction: after touching VPN 1, VPN 2 is the oldest.
    do_reset();
    fill();
    look(32'h0000_1000, 1'b0, 1'b1, 20'h11000);
    wr(20'h5, 8'h55);
    look(32'h0000_2000, 1'b0, 1'b0, 20'h00000);
    look(32'h0000_5123, 1'b0, 1'b1, 20'h55123);

    // In-place update keeps every other mapping resident.
    wr(20'h3, 8'h77);
    look(32'h0000_3FFF, 1'b0, 1'b1, 20'h77FFF);
    look(32'h0000_1000, 1'b0, 1'b1, 20'h11000);
    look(32'h0000_4000, 1'b0, 1'b1, 20'h44000);
    look(32'h0000_5000, 1'b0, 1'b1, 20'h55000);

    // Supervisor bypass must not refresh VPN 3, which is now the victim.
    look(32'hDEAD_BEEF, 1'b1, 1'b1, 20'hDBEEF);
    look(32'h0000_3123, 1'b1, 1'b1, 20'h03123);
    wr(20'h6, 8'h66);
    look(32'h0000_3000, 1'b0, 1'b0, 20'h00000);
    look(32'h0000_6ABC, 1'b0, 1'b1, 20'h66ABC);
    look(32'h0000_1000, 1'b0, 1'b1, 20'h11000);

    // Invalidate frees a slot that the next write reuses.
    inv_en  = 1'b1;
    inv_vpn = 20'h4;
    tick(1'b0, '0);
    look(32'h0000_4000, 1'b0, 1'b0, 20'h00000);
    wr(20'h7, 8'h7A);
    look(32'h0000_7000, 1'b0, 1'b1, 20'h7A000);
    look(32'h0000_1000, 1'b0, 1'b1, 20'h11000);
    look(32'h0000_5000, 1'b0, 1'b1, 20'h55000);
    look(32'h0000_6000, 1'b0, 1'b1, 20'h66000);
    inv_en  = 1'b1;
    inv_vpn = 20'h99;
    tick(1'b0, '0);
    look(32'h0000_7001, 1'b0, 1'b1, 20'h7A001);

    // Flush with a same-cycle lookup answers from the old contents.
    flush = 1'b1;
    look(32'h0000_1234, 1'b0, 1'b1, 20'h11234);
    look(32'h0000_1000, 1'b0, 1'b0, 20'h00000);
    look(32'h0000_5000, 1'b0, 1'b0, 20'h00000);
    look(32'h0000_7000, 1'b0, 1'b0, 20'h00000);

    // Write and lookup of the same VPN together: the lookup sees the old state.
    wr_en  = 1'b1;
    wr_vpn = 20'h8;
    wr_ppn = 8'h88;
    look(32'h0000_8456, 1'b0, 1'b0, 20'h00000);
    look(32'h0000_8456, 1'b0, 1'b1, 20'h88456);

    // A lookup coinciding with reset produces no response.
    reset        = 1'b1;
    lookup_valid = 1'b1;
    vaddr        = 32'h0000_8000;
    tick(1'b0, '0);
    look(32'h0000_8000, 1'b0, 1'b0, 20'h00000);

    // Random traffic over a small VPN space so hits, evictions and updates all occur.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      r               = int'($urandom_range(0, 99));
      lookup_valid    = ($urandom_range(0, 99) < 60);
      vaddr           = {20'($urandom_range(0, 7)), 12'($urandom)};
      supervisor_mode = ($urandom_range(0, 7) == 0);
      if (r < 3) begin
        flush = 1'b1;
      end else if (r < 15) begin
        inv_en  = 1'b1;
        inv_vpn = 20'($urandom_range(0, 7));
      end else if (r < 45) begin
        wr_en  = 1'b1;
        wr_vpn = 20'($urandom_range(0, 7));
        wr_ppn = 8'($urandom);
      end
      tick(1'b0, '0);
    end

    repeat (4) tick(1'b0, '0);
    check("responses_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
